// File: rtl/alu_mult_sequencer_if.sv
// Request/result and shared-ALU signals of the shift-add multiplier sequencer.
// slave = sequencer side, master = requester/ALU side.
interface alu_mult_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [2:0]       aluControl;
   logic [WIDTH-1:0] aluSrcA;
   logic [WIDTH-1:0] aluSrcB;
   logic [WIDTH-1:0] aluOut;

   modport slave (
      input  start, opA, opB, aluOut,
      output busy, done, result, aluControl, aluSrcA, aluSrcB
   );

   modport master (
      output start, opA, opB, aluOut,
      input  busy, done, result, aluControl, aluSrcA, aluSrcB
   );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned multiplier (low WIDTH bits of opA*opB) that borrows the
// shared ALU for one ADD per iteration while busy.
module alu_mult_sequencer #(
   parameter int unsigned WIDTH      = 32,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic                 clk,
   input  logic                 rstN,
   alu_mult_sequencer_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_result;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_mplier_sh;
   logic             w_last;

   assign w_mplier_sh = r_mplier >> 1;

   always_comb begin
      w_last = (r_count == CW'(1)) || (EARLY_EXIT && (w_mplier_sh == '0));
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_ITER;
         S_ITER:  if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.aluControl = 3'b000;
      bus.aluSrcA    = '0;
      bus.aluSrcB    = '0;
      if (r_state == S_ITER) begin
         bus.aluControl = 3'b010;
         bus.aluSrcA    = r_acc;
         bus.aluSrcB    = r_mplier[0] ? r_mcand : '0;
      end
   end

   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = (r_state == S_DONE);
   assign bus.result = r_result;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_acc    <= '0;
                  r_mcand  <= bus.opA;
                  r_mplier <= bus.opB;
                  r_count  <= CW'(WIDTH);
               end
            end
            S_ITER: begin
               r_acc    <= bus.aluOut;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_sh;
               r_count  <= r_count - CW'(1);
               // Result loads with the final sum so it is already valid while done is high.
               if (w_last) r_result <= bus.aluOut;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench: two sequencers (EARLY_EXIT=1 and 0) with a behavioural ALU,
// expected products/latencies queued by the driver and checked by a negedge monitor.
module tb_alu_mult_sequencer;
   localparam int unsigned W = 32;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   alu_mult_sequencer_if #(.WIDTH(W)) bus0 ();
   alu_mult_sequencer_if #(.WIDTH(W)) bus1 ();

   alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (.clk(clk), .rstN(rstN), .bus(bus0));
   alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (.clk(clk), .rstN(rstN), .bus(bus1));

   assign bus0.aluOut = (bus0.aluControl == 3'b010) ? bus0.aluSrcA + bus0.aluSrcB : '0;
   assign bus1.aluOut = (bus1.aluControl == 3'b010) ? bus1.aluSrcA + bus1.aluSrcB : '0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      int unsigned acc_cyc;
      int unsigned done_cyc;
   } exp_t;

   exp_t        qs[2][$];
   logic [31:0] last_res[2];
   int unsigned free_cyc[2];
   int unsigned cyc   = 0;
   int          total = 0;
   int          bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
      end
   endtask

   function automatic int unsigned iters(input int d, input logic [31:0] b);
      if (d == 1) return W;
      for (int i = 31; i >= 0; i--)
         if (b[i]) return i + 1;
      return 1;
   endfunction

   task automatic mon(input int d, input logic busy, input logic done, input logic [31:0] result,
                      input logic [2:0] ctl, input logic [31:0] sa, input logic [31:0] sb);
      exp_t        e;
      int unsigned k;
      logic [31:0] mask;
      if (qs[d].size() == 0) begin
         chk(d, "idle_busy", {31'd0, busy}, 32'd0);
         chk(d, "idle_done", {31'd0, done}, 32'd0);
         chk(d, "idle_ctl", {29'd0, ctl}, 32'd0);
         chk(d, "idle_srcA", sa, 32'd0);
         chk(d, "idle_srcB", sb, 32'd0);
         chk(d, "held_result", result, last_res[d]);
      end else begin
         e = qs[d][0];
         chk(d, "busy", {31'd0, busy}, 32'd1);
         if (cyc < e.done_cyc) begin
            k    = cyc - e.acc_cyc;
            mask = (32'h1 << k) - 32'h1;
            chk(d, "iter_done", {31'd0, done}, 32'd0);
            chk(d, "iter_ctl", {29'd0, ctl}, 32'd2);
            chk(d, "iter_srcA", sa, e.a * (e.b & mask));
            chk(d, "iter_srcB", sb, e.b[k] ? (e.a << k) : 32'd0);
         end else begin
            chk(d, "done_pulse", {31'd0, done}, 32'd1);
            chk(d, "result", result, e.prod);
            chk(d, "done_ctl", {29'd0, ctl}, 32'd0);
            last_res[d] = e.prod;
            void'(qs[d].pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (rstN) begin
         mon(0, bus0.busy, bus0.done, bus0.result, bus0.aluControl, bus0.aluSrcA, bus0.aluSrcB);
         mon(1, bus1.busy, bus1.done, bus1.result, bus1.aluControl, bus1.aluSrcA, bus1.aluSrcB);
      end
   end

   task automatic drive(input int d, input logic s, input logic [31:0] a, input logic [31:0] b);
      if (d == 0) begin
         bus0.start = s; bus0.opA = a; bus0.opB = b;
      end else begin
         bus1.start = s; bus1.opA = a; bus1.opB = b;
      end
   endtask

   // Drives start once the model says the DUT is idle; start is left high.
   task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      int unsigned n;
      @(negedge clk);
      while (cyc + 1 < free_cyc[d]) @(negedge clk);
      drive(d, 1'b1, a, b);
      @(posedge clk);
      #1;
      n          = iters(d, b);
      e.a        = a;
      e.b        = b;
      e.prod     = a * b;
      e.acc_cyc  = cyc;
      e.done_cyc = cyc + n;
      qs[d].push_back(e);
      free_cyc[d] = cyc + n + 2;
   endtask

   task automatic release_start(input int d);
      @(negedge clk);
      drive(d, 1'b0, $urandom, $urandom);
   endtask

   task automatic reset_checks();
      chk(0, "rst_busy", {31'd0, bus0.busy}, 32'd0);
      chk(0, "rst_done", {31'd0, bus0.done}, 32'd0);
      chk(0, "rst_result", bus0.result, 32'd0);
      chk(0, "rst_ctl", {29'd0, bus0.aluControl}, 32'd0);
      chk(1, "rst_busy", {31'd0, bus1.busy}, 32'd0);
      chk(1, "rst_result", bus1.result, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      drive(0, 1'b0, '0, '0);
      drive(1, 1'b0, '0, '0);
      last_res[0] = '0;
      last_res[1] = '0;
      #1;
      reset_checks();
      repeat (3) @(negedge clk);
      #2 rstN = 1'b1;
      free_cyc[0] = cyc + 1;
      free_cyc[1] = cyc + 1;

      start_op(0, 32'd7, 32'd6);              release_start(0);
      start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); release_start(0);
      start_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); release_start(1);
      start_op(0, 32'd123, 32'd0);            release_start(0);
      start_op(1, 32'd123, 32'd0);            release_start(1);

      // start pulsed mid-operation with other operands must be ignored
      start_op(0, 32'h55, 32'h100);
      release_start(0);
      @(negedge clk);
      @(negedge clk);
      drive(0, 1'b1, 32'd9, 32'd9);
      @(negedge clk);
      drive(0, 1'b0, 32'd3, 32'd3);

      // start held high across done: second op accepted the cycle after DONE
      start_op(0, 32'd1000, 32'd77);
      start_op(0, 32'd5, 32'd11);
      release_start(0);
      start_op(1, 32'hDEAD_BEEF, 32'd3);
      start_op(1, 32'd12345, 32'h8000_0001);
      release_start(1);

      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) b = '0;
         start_op(i % 2, a, b);
         release_start(i % 2);
      end

      // asynchronous reset while dut0 iterates: no done pulse afterwards
      start_op(0, 32'h1234_5678, 32'h0000_FFFF);
      release_start(0);
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      reset_checks();
      qs[0].delete();
      qs[1].delete();
      last_res[0] = '0;
      last_res[1] = '0;
      @(negedge clk);
      #2 rstN = 1'b1;
      free_cyc[0] = cyc + 1;
      free_cyc[1] = cyc + 1;
      repeat (20) @(negedge clk);

      start_op(0, 32'd9, 32'd9); release_start(0);

      for (int t = 0; t < 100 && (qs[0].size() != 0 || qs[1].size() != 0); t++) @(negedge clk);
      total++;
      if (qs[0].size() != 0 || qs[1].size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d/%0d pending required=0/0", qs[0].size(), qs[1].size());
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
